// File: rtl/y86_writeback_rf_if.sv
// Writeback/register-file port bundle: M-stage inputs, W control, decode read ports and status outputs.
// No timing of its own; the master drives the stage inputs and the slave returns the read data and status.
interface y86_writeback_rf_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic              w_stall;
  logic              w_bubble;
  logic [3:0]        m_icode;
  logic              m_cnd;
  logic [2:0]        m_stat;
  logic [3:0]        m_rA;
  logic [3:0]        m_rB;
  logic [DATA_W-1:0] m_valE;
  logic [DATA_W-1:0] m_valM;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  logic [2:0]        w_stat;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    output w_stall, w_bubble, m_icode, m_cnd, m_stat, m_rA, m_rB, m_valE, m_valM, srcA, srcB,
    input  valA, valB, dstE, dstM, w_stat, halted, retired
  );

  modport slave (
    input  w_stall, w_bubble, m_icode, m_cnd, m_stat, m_rA, m_rB, m_valE, m_valM, srcA, srcB,
    output valA, valB, dstE, dstM, w_stat, halted, retired
  );
endinterface

// File: rtl/y86_writeback_rf.sv
// PIPE writeback stage: W register, dstE/dstM decode, register file with write-through read ports.
// Reads are combinational; the W register holds on w_stall while its commit repeats idempotently.
module y86_writeback_rf #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int RSP_ID = 4,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  y86_writeback_rf_if.slave wb
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'(RSP_ID);
  localparam logic [4:0] NREGS_L  = 5'(NREGS);
  localparam logic [2:0] STAT_AOK = 3'd1;

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [3:0]        r_icode;
  logic              r_cnd;
  logic [2:0]        r_stat;
  logic [3:0]        r_rA;
  logic [3:0]        r_rB;
  logic [DATA_W-1:0] r_valE;
  logic [DATA_W-1:0] r_valM;
  logic [DATA_W-1:0] r_rf [16];
  logic              r_halted;
  logic [CNT_W-1:0]  r_retired;

  logic [3:0]        w_dstE;
  logic [3:0]        w_dstM;
  logic              w_commit;
  logic              w_weE;
  logic              w_weM;
  logic [DATA_W-1:0] w_valA;
  logic [DATA_W-1:0] w_valB;

  function automatic logic f_in_rf(input logic [3:0] id);
    return (id != RNONE) && ({1'b0, id} < NREGS_L);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || (!wb.w_stall && wb.w_bubble)) begin
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_stat  <= STAT_AOK;
      r_rA    <= RNONE;
      r_rB    <= RNONE;
      r_valE  <= '0;
      r_valM  <= '0;
    end else if (!wb.w_stall) begin
      r_icode <= wb.m_icode;
      r_cnd   <= wb.m_cnd;
      r_stat  <= wb.m_stat;
      r_rA    <= wb.m_rA;
      r_rB    <= wb.m_rB;
      r_valE  <= wb.m_valE;
      r_valM  <= wb.m_valM;
    end
  end

  always_comb begin
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (r_icode)
      I_CMOV:                 if (r_cnd) w_dstE = r_rB;
      I_IRMOV, I_OP:          w_dstE = r_rB;
      I_CALL, I_RET, I_PUSH:  w_dstE = RSP;
      I_POP: begin
        w_dstE = RSP;
        w_dstM = r_rA;
      end
      I_MRMOV:                w_dstM = r_rA;
      default: ;
    endcase
  end

  // A faulting instruction, and everything after it, never reaches the register file.
  assign w_commit = !r_halted && (r_stat == STAT_AOK);
  assign w_weE    = w_commit && f_in_rf(w_dstE);
  assign w_weM    = w_commit && f_in_rf(w_dstM);

  // The M port is checked first so popq %rsp leaves the loaded value in %rsp.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (rst) begin
        r_rf[i] <= '0;
      end else if (w_weM && (w_dstM == 4'(i))) begin
        r_rf[i] <= r_valM;
      end else if (w_weE && (w_dstE == 4'(i))) begin
        r_rf[i] <= r_valE;
      end
    end
  end

  always_comb begin
    w_valA = '0;
    if (f_in_rf(wb.srcA)) begin
      if (w_weM && (wb.srcA == w_dstM))      w_valA = r_valM;
      else if (w_weE && (wb.srcA == w_dstE)) w_valA = r_valE;
      else                                   w_valA = r_rf[wb.srcA];
    end
  end

  always_comb begin
    w_valB = '0;
    if (f_in_rf(wb.srcB)) begin
      if (w_weM && (wb.srcB == w_dstM))      w_valB = r_valM;
      else if (w_weE && (wb.srcB == w_dstE)) w_valB = r_valE;
      else                                   w_valB = r_rf[wb.srcB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_stat != STAT_AOK) r_halted <= 1'b1;
      if ((r_icode != I_NOP) && !wb.w_stall && !r_halted) r_retired <= r_retired + 1'b1;
    end
  end

  assign wb.valA    = w_valA;
  assign wb.valB    = w_valB;
  assign wb.dstE    = w_dstE;
  assign wb.dstM    = w_dstM;
  assign wb.w_stat  = r_stat;
  assign wb.halted  = r_halted;
  assign wb.retired = r_retired;

endmodule

// File: tb/tb_y86_writeback_rf.sv
// Bench for y86_writeback_rf: directed PIPE writeback scenarios followed by random traffic,
// checked per cycle against an architectural model through an expected-response queue.
module tb_y86_writeback_rf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y86_writeback_rf_if #(.DATA_W(64), .CNT_W(32)) bus ();

  y86_writeback_rf #(.DATA_W(64), .NREGS(15), .RSP_ID(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  typedef struct {
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Architectural model: register array plus the instruction sitting in W.
  logic [63:0] mrf [15];
  logic [3:0]  mw_icode, mw_rA, mw_rB;
  logic        mw_cnd;
  logic [2:0]  mw_stat;
  logic [63:0] mw_valE, mw_valM;
  logic        m_halted;
  logic [31:0] m_retired;

  function automatic logic [3:0] ref_dstE(input logic [3:0] ic, input logic c, input logic [3:0] rb);
    if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic == 4'h5 || ic == 4'hB) return ra;
    return 4'hF;
  endfunction

  task automatic load_bubble();
    mw_icode = 4'h1; mw_cnd = 1'b0; mw_stat = 3'd1;
    mw_rA = 4'hF; mw_rB = 4'hF; mw_valE = '0; mw_valM = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mrf[i] = '0;
    load_bubble();
    m_halted = 1'b0;
    m_retired = '0;
  endtask

  // Drive one cycle, queue the response expected before the next edge, then advance the model.
  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [3:0] ic, input logic c, input logic [2:0] st,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    logic [63:0] nrf [15];
    logic [3:0]  de, dm;
    exp_t        e;
    rst = r;
    bus.w_stall = s; bus.w_bubble = b;
    bus.m_icode = ic; bus.m_cnd = c; bus.m_stat = st;
    bus.m_rA = ra; bus.m_rB = rb; bus.m_valE = ve; bus.m_valM = vm;
    bus.srcA = sa; bus.srcB = sb;

    de = ref_dstE(mw_icode, mw_cnd, mw_rB);
    dm = ref_dstM(mw_icode, mw_rA);
    // Register state once this W instruction retires; reads forward exactly that view.
    nrf = mrf;
    if (!m_halted && mw_stat == 3'd1) begin
      if (de < 4'd15) nrf[de] = mw_valE;
      if (dm < 4'd15) nrf[dm] = mw_valM;
    end
    e.valA = (sa < 4'd15) ? nrf[sa] : 64'd0;
    e.valB = (sb < 4'd15) ? nrf[sb] : 64'd0;
    e.dstE = de;
    e.dstM = dm;
    e.stat = mw_stat;
    e.halted = m_halted;
    e.retired = m_retired;
    q.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      mrf = nrf;
      if (mw_icode != 4'h1 && !s && !m_halted) m_retired = m_retired + 1;
      if (mw_stat != 3'd1) m_halted = 1'b1;
      if (!s) begin
        if (b) load_bubble();
        else begin
          mw_icode = ic; mw_cnd = c; mw_stat = st; mw_rA = ra; mw_rB = rb;
          mw_valE = ve; mw_valM = vm;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [3:0] ic, input logic c, input logic [2:0] st,
                    input logic [3:0] ra, input logic [3:0] rb,
                    input logic [63:0] ve, input logic [63:0] vm,
                    input logic [3:0] sa, input logic [3:0] sb);
    drive(1'b0, 1'b0, 1'b0, ic, c, st, ra, rb, ve, vm, sa, sb);
  endtask

  task automatic idle(input int n, input logic [3:0] sa, input logic [3:0] sb);
    repeat (n) drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd1, 4'hF, 4'hF, 64'd0, 64'd0, sa, sb);
  endtask

  task automatic stall(input int n, input logic b, input logic [3:0] sa, input logic [3:0] sb);
    repeat (n) drive(1'b0, 1'b1, b, 4'($urandom_range(11)), 1'($urandom), 3'd1,
                     4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, sa, sb);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valA",    bus.valA,            e.valA);
        chk("valB",    bus.valB,            e.valB);
        chk("dstE",    64'(bus.dstE),       64'(e.dstE));
        chk("dstM",    64'(bus.dstM),       64'(e.dstM));
        chk("w_stat",  64'(bus.w_stat),     64'(e.stat));
        chk("halted",  64'(bus.halted),     64'(e.halted));
        chk("retired", 64'(bus.retired),    64'(e.retired));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [2:0] st;
    rst = 1'b1;
    bus.w_stall = 1'b0; bus.w_bubble = 1'b0;
    bus.m_icode = 4'h1; bus.m_cnd = 1'b0; bus.m_stat = 3'd1;
    bus.m_rA = 4'hF; bus.m_rB = 4'hF; bus.m_valE = '0; bus.m_valM = '0;
    bus.srcA = 4'hF; bus.srcB = 4'hF;
    @(posedge clk);
    #1;
    model_reset();

    drive(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 3'd1, 4'hF, 4'hF, 64'd0, 64'd0, 4'd2, 4'hF);
    // irmovq $0x55, %rdx
    ld(4'h3, 1'b0, 3'd1, 4'hF, 4'd2, 64'h55, 64'd0, 4'd2, 4'd0);
    idle(2, 4'd2, 4'd0);
    // cmovXX not taken, then taken
    ld(4'h2, 1'b0, 3'd1, 4'd1, 4'd7, 64'd9, 64'd0, 4'd7, 4'd2);
    idle(2, 4'd7, 4'd2);
    ld(4'h2, 1'b1, 3'd1, 4'd1, 4'd7, 64'd9, 64'd0, 4'd7, 4'd2);
    idle(2, 4'd7, 4'd2);
    // popq %rsp
    ld(4'hB, 1'b0, 3'd1, 4'd4, 4'hF, 64'h108, 64'h200, 4'd4, 4'd4);
    idle(2, 4'd4, 4'd7);
    // OPq held by a 3-cycle stall
    ld(4'h6, 1'b0, 3'd1, 4'd0, 4'd3, 64'd7, 64'd0, 4'd3, 4'd4);
    stall(3, 1'b0, 4'd3, 4'd2);
    idle(2, 4'd3, 4'd15);
    // stall and bubble together
    ld(4'h6, 1'b0, 3'd1, 4'd1, 4'd5, 64'h11, 64'd0, 4'd5, 4'd3);
    stall(2, 1'b1, 4'd5, 4'd3);
    idle(2, 4'd5, 4'd14);
    // address fault, then a younger irmovq that must not write
    ld(4'h5, 1'b0, 3'd3, 4'd1, 4'hF, 64'd0, 64'hFF, 4'd1, 4'd2);
    ld(4'h3, 1'b0, 3'd1, 4'hF, 4'd2, 64'd1, 64'd0, 4'd1, 4'd2);
    idle(3, 4'd1, 4'd2);
    drive(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 3'd1, 4'hF, 4'd2, 64'd1, 64'd0, 4'd2, 4'd4);
    idle(2, 4'd2, 4'd4);

    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(99) < 3) ? 3'($urandom_range(4, 2)) : 3'd1;
      drive(1'($urandom_range(99) < 2), 1'($urandom_range(99) < 20), 1'($urandom_range(99) < 15),
            4'($urandom_range(11)), 1'($urandom), st, 4'($urandom), 4'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 4'($urandom));
    end

    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d expected responses left, required 0", q.size());
    end
    if (n_vec < 12) begin
      n_err++;
      $display("FAIL vector_count: only %0d comparisons made", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
